// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; holds EX via stall until done.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after start.
`ifndef ALU_SEL_W
`define ALU_SEL_W 5
`endif
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`endif
`ifndef ALU_DIV
`define ALU_DIV  5'd16
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd17
`endif
`ifndef ALU_REM
`define ALU_REM  5'd18
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd19
`endif

module div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [`ALU_SEL_W-1:0] alu_ctl,
   input  logic [XLEN-1:0]       src_a,
   input  logic [XLEN-1:0]       src_b,
   input  logic                  flush,
   output logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  res_q, res_d;
   logic             is_rem_q, is_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             divz_q, divz_d;

   logic            is_div_op, is_signed, is_rem_op;
   logic            a_neg, b_neg, accept;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_step, quo_step;

   // Sign/special-case fix-up; divide-by-zero remainder falls out naturally as |a| with a's sign.
   function automatic logic [XLEN-1:0] fixup(input logic            is_rem,
                                             input logic            neg_quo,
                                             input logic            neg_rem,
                                             input logic            divz,
                                             input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] r);
      logic [XLEN-1:0] v;
      if (is_rem)    v = neg_rem ? -r : r;
      else if (divz) v = '1;
      else           v = neg_quo ? -q : q;
      return v;
   endfunction

   always_comb begin
      is_div_op = (alu_ctl == `ALU_DIV) || (alu_ctl == `ALU_DIVU) ||
                  (alu_ctl == `ALU_REM) || (alu_ctl == `ALU_REMU);
      is_signed = (alu_ctl == `ALU_DIV) || (alu_ctl == `ALU_REM);
      is_rem_op = (alu_ctl == `ALU_REM) || (alu_ctl == `ALU_REMU);
      a_neg     = is_signed & src_a[XLEN-1];
      b_neg     = is_signed & src_b[XLEN-1];
      mag_a     = a_neg ? -src_a : src_a;
      mag_b     = b_neg ? -src_b : src_b;
      accept    = (state_q == S_IDLE) && start && is_div_op && !flush;
   end

   always_comb begin
      rem_sh   = {rem_q, quo_q[XLEN-1]};
      ge       = (rem_sh >= {1'b0, dvs_q});
      quo_step = {quo_q[XLEN-2:0], ge};
      rem_step = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      res_d     = res_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      divz_d    = divz_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               is_rem_d  = is_rem_op;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               divz_d    = (src_b == '0);
               dvs_d     = mag_b;
               quo_d     = mag_a;
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
               if ((src_b == '0) ||
                   (is_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1))) begin
                  state_d = S_DONE;
                  res_d   = fixup(is_rem_op, a_neg ^ b_neg, a_neg, src_b == '0,
                                  (src_b == '0) ? '0 : {1'b1, {(XLEN-1){1'b0}}},
                                  (src_b == '0) ? mag_a : '0);
               end
`endif
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_d = S_DONE;
                  res_d   = fixup(is_rem_q, neg_quo_q, neg_rem_q, divz_q, quo_step, rem_step);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         res_q     <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         divz_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         res_q     <= res_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         divz_q    <= divz_d;
      end
   end

   assign stall  = accept || (state_q == S_CALC);
   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_DONE);
   assign result = res_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sits in EX, directly downstream of ALUControl, and consumes its ALUCtl output alongside the ALU.
- Holds the pipeline through a stall output until the quotient or remainder is ready.
- The single-cycle ALU keeps every other ALUCtl code.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, $clog2(XLEN)+1: width of the iteration counter.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX-stage instruction valid.
- alu_ctl  in  `ALU_SEL_W  operation select from ALUControl.
- src_a  in  XLEN  dividend (rs1).
- src_b  in  XLEN  divisor (rs2).
- flush  in  1  pipeline kill; aborts any operation in flight.
- stall  out  1  freezes IF/ID/EX while the divide is pending.
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse; result is valid during it.
- result  out  XLEN  quotient or remainder.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Divide op: alu_ctl equals `ALU_DIV, `ALU_DIVU, `ALU_REM or `ALU_REMU (def.h). Every other code is ignored: no state change, stall=0.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, all datapath registers 0.
- States:
  - IDLE: start & divide op & !flush -> CALC. Latch op kind and sign flags; load unsigned magnitudes |src_a| and |src_b| (raw values for the U forms); clear the partial remainder; counter=0.
  - CALC: one restoring step per cycle. Shift {rem,quo} left by 1; trial = rem - divisor; if trial is non-negative, rem=trial and quo[0]=1. Counter increments. After the step with counter==XLEN-1 -> DONE.
  - DONE: done=1 and result driven for exactly one cycle -> IDLE.
- Latency: start cycle T; done at T+XLEN+1 (T+33 for XLEN=32).
- stall = (state==IDLE & start & divide op & !flush) | (state==CALC). stall=0 in DONE, so the EX/MEM register captures result on that edge.
- Sign fix-up, applied when entering DONE:
  - Quotient is negated when the signs of src_a and src_b differ (DIV only).
  - Remainder takes the sign of src_a (REM only).
- RISC-V special cases; the result must match exactly:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give src_a.
  - Signed overflow, 0x80000000 / -1: DIV gives 0x80000000; REM gives 0.
- result holds its value after DONE until the next DONE; only the done pulse marks it valid.
- start asserted while in CALC or DONE is ignored. The stalled pipeline re-presents the same instruction; this is not a new request.
- flush:
  - In CALC: next state is IDLE, no done, result unchanged.
  - In IDLE together with start: flush wins and nothing is accepted.
  - In DONE: done still pulses; the downstream flush logic discards it.
- rst_n low mid-operation: immediately return to the reset values; no done pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed overflow skip CALC. IDLE goes directly to DONE with the special-case result, so done appears at T+1. stall is asserted in cycle T only.
- Not defined: the special cases run the full XLEN iterations, and the fix-up logic produces the same values at T+XLEN+1.
- Normal operands take the same latency with or without the macro.

Test Plan:
- DIV src_a=100, src_b=7 -> done at T+33, result=14; REM with the same operands -> 2; stall high in cycles T..T+32.
- REM src_a=0xFFFFFFF9 (-7), src_b=2 -> result=0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
- DIVU src_b=0, src_a=0x1234 -> 0xFFFFFFFF; REMU -> 0x1234. Latency is T+33, or T+1 with DIV_EARLY_OUT_EN.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- DIVU at T, flush at T+10 -> busy=0 and stall=0 from T+11; no done pulse. A following DIVU 9/3 -> 3 at its T'+33.
- rst_n pulsed low at T+5 of a DIV -> all outputs 0 immediately, no done. A new op after release completes normally.
- start with alu_ctl=`ALU_ADD -> stall=0, busy=0, no done.
